// File: rtl/vadd_pkg.sv
// Shared definitions for the vadd sum-reduction block: FSM state encoding,
// start hold-off length and the width of a per-unit sum.
package vadd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Cycles spent ignoring unit valids after a start; covers the units'
    // 2-cycle start pipeline so stale valids from the previous run are masked.
    localparam int START_HOLDOFF = 4;

    // Width of one unit sum and of the reduced result.
    localparam int SUM_W = 64;

endpackage

// File: rtl/vadd_sum_reduce.sv
// Serial reduction of NUM_UNITS per-unit vadd sums into one 64-bit total.
// After a start, waits out a short hold-off, then waits for every unit to
// report valid (or for an optional timeout), then adds one unit per cycle
// into a 65-bit accumulator whose carry is folded into a sticky overflow.
module vadd_sum_reduce
    import vadd_pkg::*;
#(
    parameter int NUM_UNITS = 8,
    parameter int TMO_W     = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_UNITS*64-1:0]    unit_sum,
    input  logic [NUM_UNITS-1:0]       unit_sum_vld,
    input  logic [NUM_UNITS-1:0]       unit_sum_ovrflw,
    input  logic [NUM_UNITS-1:0]       unit_res_ovrflw,
    input  logic [TMO_W-1:0]           csr_timeout,
    output logic [63:0]                total_sum,
    output logic                       total_vld,
    output logic                       total_ovrflw,
    output logic                       res_ovrflw_any,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int                   IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_UNITS - 1);
    localparam logic [NUM_UNITS-1:0] ALL_VLD  = '1;
    localparam logic [2:0]           HOLD_LAST = 3'(START_HOLDOFF - 1);

    state_t                 state;
    state_t                 state_nxt;

    logic [SUM_W:0]         acc;
    logic [IDX_W-1:0]       idx;
    logic [2:0]             hold_cnt;
    logic [TMO_W-1:0]       wait_cnt;
    logic [NUM_UNITS-1:0]   mask;
    logic                   done_vld;
    logic                   sum_ovf;
    logic                   res_ovf;
    logic                   tmo_err;

    logic                   all_vld;
    logic [TMO_W-1:0]       wait_cnt_inc;
    logic                   tmo_hit;
    logic                   hold_last;
    logic                   idx_last;
    logic [SUM_W-1:0]       sel_sum;
    logic                   sel_ovf;
    logic                   sel_mask;
    logic [SUM_W:0]         acc_sum;

    assign all_vld      = (unit_sum_vld == ALL_VLD);
    assign wait_cnt_inc = wait_cnt + 1'b1;
    // Fires on the WAIT cycle whose count of elapsed WAIT cycles reaches the limit.
    assign tmo_hit      = (csr_timeout != '0) && (wait_cnt_inc == csr_timeout);
    assign hold_last    = (hold_cnt == HOLD_LAST);
    assign idx_last     = (idx == IDX_LAST);

    // Select the unit currently addressed by idx, together with its latched mask bit.
    always_comb begin
        sel_sum  = '0;
        sel_ovf  = 1'b0;
        sel_mask = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_sum  = unit_sum[64*i +: 64];
                sel_ovf  = unit_sum_ovrflw[i];
                sel_mask = mask[i];
            end
        end
    end

    // Serial adder: masked-out units contribute zero; bit 64 is the carry out.
    assign acc_sum = acc + {1'b0, (sel_mask ? sel_sum : {SUM_W{1'b0}})};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start restarts from any state, including mid-run aborts.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_HOLD;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_HOLD:  if (hold_last) state_nxt = ST_WAIT;
                ST_WAIT:  if (all_vld || tmo_hit) state_nxt = ST_ACCUM;
                ST_ACCUM: if (idx_last) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            wait_cnt <= '0;
            mask     <= '0;
            done_vld <= 1'b0;
            sum_ovf  <= 1'b0;
            res_ovf  <= 1'b0;
            tmo_err  <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            wait_cnt <= '0;
            mask     <= '0;
            done_vld <= 1'b0;
            sum_ovf  <= 1'b0;
            res_ovf  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 3'd1;
                    if (|unit_res_ovrflw) res_ovf <= 1'b1;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt_inc;
                    if (|unit_res_ovrflw) res_ovf <= 1'b1;
                    if (all_vld) begin
                        mask <= ALL_VLD;
                        idx  <= '0;
                    end else if (tmo_hit) begin
                        mask    <= unit_sum_vld;
                        idx     <= '0;
                        tmo_err <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (|unit_res_ovrflw) res_ovf <= 1'b1;
                    // Carry is folded into the sticky flag; the sum wraps mod 2^64.
                    acc <= {1'b0, acc_sum[SUM_W-1:0]};
                    if (acc_sum[SUM_W] || (sel_mask && sel_ovf)) sum_ovf <= 1'b1;
                    if (idx_last) begin
                        done_vld <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs; the sum is gated so it reads zero until the result is valid.
    always_comb begin
        busy           = (state == ST_HOLD) || (state == ST_WAIT) || (state == ST_ACCUM);
        total_vld      = done_vld;
        total_sum      = done_vld ? acc[SUM_W-1:0] : 64'd0;
        total_ovrflw   = sum_ovf;
        res_ovrflw_any = res_ovf;
        timeout_err    = tmo_err;
    end

endmodule

// File: tb/tb_vadd_sum_reduce.sv
// Directed bench for vadd_sum_reduce with NUM_UNITS=4: a per-cycle compare
// against an arithmetic model of the reduction, plus literal expectations
// for results, latencies and flag behaviour.
module tb_vadd_sum_reduce;

    localparam int N     = 4;
    localparam int TMO_W = 20;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [N*64-1:0]    unit_sum;
    logic [N-1:0]       unit_sum_vld;
    logic [N-1:0]       unit_sum_ovrflw;
    logic [N-1:0]       unit_res_ovrflw;
    logic [TMO_W-1:0]   csr_timeout;
    logic [63:0]        total_sum;
    logic               total_vld;
    logic               total_ovrflw;
    logic               res_ovrflw_any;
    logic               timeout_err;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_sum = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_tmo = 1'b0;
    logic        exp_res = 1'b0;

    vadd_sum_reduce #(.NUM_UNITS(N), .TMO_W(TMO_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .unit_sum        (unit_sum),
        .unit_sum_vld    (unit_sum_vld),
        .unit_sum_ovrflw (unit_sum_ovrflw),
        .unit_res_ovrflw (unit_res_ovrflw),
        .csr_timeout     (csr_timeout),
        .total_sum       (total_sum),
        .total_vld       (total_vld),
        .total_ovrflw    (total_ovrflw),
        .res_ovrflw_any  (res_ovrflw_any),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reduction as plain wide arithmetic: the sticky overflow is set iff the
    // true sum of masked units exceeds 64 bits or a masked unit flagged overflow.
    function automatic void model(input logic [N*64-1:0] sums, input logic [N-1:0] m,
                                  input logic [N-1:0] sov, output logic [63:0] s,
                                  output logic ov);
        logic [127:0] total;
        total = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) total = total + {64'd0, sums[64*i +: 64]};
        end
        s  = total[63:0];
        ov = (total[127:64] != 64'd0) || ((m & sov) != '0);
    endfunction

    task automatic set_model(input logic [N-1:0] m, input logic tmo, input logic res);
        logic [63:0] s;
        logic        ov;
        model(unit_sum, m, unit_sum_ovrflw, s, ov);
        exp_sum = s;
        exp_ovf = ov;
        exp_tmo = tmo;
        exp_res = res;
    endtask

    task automatic set_sums(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
        unit_sum = {d, c, b, a};
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count rising edges until total_vld is seen; bounded.
    task automatic wait_total(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (total_vld) break;
        end
        if (!total_vld) chk("total_vld_wait_expired", 64'd0, 64'd1);
    endtask

    // Per-cycle compare against the model whenever a result is presented.
    always @(negedge clk) begin
        if (total_vld) begin
            chk("cmp_sum",  total_sum, exp_sum);
            chk("cmp_ovf",  64'(total_ovrflw), 64'(exp_ovf));
            chk("cmp_tmo",  64'(timeout_err), 64'(exp_tmo));
            chk("cmp_res",  64'(res_ovrflw_any), 64'(exp_res));
            chk("cmp_busy_in_done", 64'(busy), 64'd0);
        end else begin
            chk("cmp_sum_zero_invalid", total_sum, 64'd0);
        end
    end

    initial begin
        int n;
        logic [63:0] ms;
        logic        mo;

        reset           = 1'b1;
        start           = 1'b0;
        unit_sum        = '0;
        unit_sum_vld    = '0;
        unit_sum_ovrflw = '0;
        unit_res_ovrflw = '0;
        csr_timeout     = '0;

        // Model self-test against hand-computed values.
        model({64'd4, 64'd3, 64'd2, 64'd1}, 4'hF, 4'h0, ms, mo);
        chk("model_sum_10", ms, 64'd10);
        model({64'd0, 64'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF}, 4'hF, 4'h0, ms, mo);
        chk("model_wrap_sum", ms, 64'd1);
        chk("model_wrap_ovf", 64'(mo), 64'd1);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vld",  64'(total_vld), 64'd0);
        chk("rst_sum",  total_sum, 64'd0);
        chk("rst_flags", {60'd0, total_ovrflw, res_ovrflw_any, timeout_err, 1'b0}, 64'd0);
        reset = 1'b0;

        // No action without a start, even with all valids high.
        unit_sum_vld = 4'hF;
        set_sums(64'd7, 64'd7, 64'd7, 64'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_vld",  64'(total_vld), 64'd0);

        // Scenario 1: sums 1..4, valids rise well after start.
        unit_sum_vld = 4'h0;
        set_sums(64'd1, 64'd2, 64'd3, 64'd4);
        do_start();
        set_model(4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("s1_busy_after_start", 64'(busy), 64'd1);
        repeat (8) @(posedge clk);
        #1 unit_sum_vld = 4'hF;
        wait_total(n);
        chk("s1_latency", 64'(n), 64'd5);
        chk("s1_sum", total_sum, 64'd10);
        chk("s1_ovf", 64'(total_ovrflw), 64'd0);
        chk("s1_tmo", 64'(timeout_err), 64'd0);
        repeat (3) @(negedge clk);
        chk("s1_hold_vld", 64'(total_vld), 64'd1);
        chk("s1_hold_sum", total_sum, 64'd10);

        // Scenario 2: carry out of 64 bits wraps and sets the sticky flag.
        unit_sum_vld = 4'h0;
        set_sums(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0);
        do_start();
        set_model(4'hF, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 unit_sum_vld = 4'hF;
        wait_total(n);
        chk("s2_sum", total_sum, 64'd1);
        chk("s2_ovf", 64'(total_ovrflw), 64'd1);

        // Scenario 3: unit 2 never valid, timeout after 50 WAIT cycles; its
        // overflow flag is outside the mask and must not count.
        csr_timeout     = 20'd50;
        unit_sum_vld    = 4'b1011;
        unit_sum_ovrflw = 4'b0100;
        set_sums(64'd5, 64'd6, 64'd7, 64'd8);
        do_start();
        set_model(4'b1011, 1'b1, 1'b0);
        wait_total(n);
        chk("s3_latency_from_start", 64'(n), 64'd58);
        chk("s3_sum", total_sum, 64'd19);
        chk("s3_tmo", 64'(timeout_err), 64'd1);
        chk("s3_ovf", 64'(total_ovrflw), 64'd0);
        csr_timeout     = '0;
        unit_sum_ovrflw = '0;

        // Scenario 4: stale all-valid through start, drops, then re-rises.
        unit_sum_vld = 4'hF;
        do_start();
        @(posedge clk);
        #1 unit_sum_vld = 4'h0;
        set_sums(64'd11, 64'd22, 64'd33, 64'd44);
        set_model(4'hF, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("s4_still_waiting", 64'(busy), 64'd1);
        chk("s4_no_vld", 64'(total_vld), 64'd0);
        @(posedge clk);
        #1 unit_sum_vld = 4'hF;
        wait_total(n);
        chk("s4_latency", 64'(n), 64'd5);
        chk("s4_sum", total_sum, 64'd110);

        // Scenario 5: abort during ACCUM after a carry and an element overflow.
        unit_sum_vld = 4'h0;
        set_sums(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
        do_start();
        repeat (5) @(posedge clk);
        #1 unit_res_ovrflw = 4'b0010;
        @(posedge clk);
        #1 unit_res_ovrflw = 4'b0000;
        @(negedge clk);
        chk("s5_res_sticky", 64'(res_ovrflw_any), 64'd1);
        @(posedge clk);
        #1 unit_sum_vld = 4'hF;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("s5_ovf_before_abort", 64'(total_ovrflw), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        unit_sum_vld = 4'h0;
        set_sums(64'd3, 64'd0, 64'd0, 64'd4);
        set_model(4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("s5_busy", 64'(busy), 64'd1);
        chk("s5_vld_clr", 64'(total_vld), 64'd0);
        chk("s5_ovf_clr", 64'(total_ovrflw), 64'd0);
        chk("s5_res_clr", 64'(res_ovrflw_any), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("s5_no_aborted_vld", 64'(total_vld), 64'd0);
        end
        @(posedge clk);
        #1 unit_sum_vld = 4'hF;
        wait_total(n);
        chk("s5_latency", 64'(n), 64'd5);
        chk("s5_sum", total_sum, 64'd7);

        // Scenario 6: asynchronous reset in WAIT clears everything at once.
        unit_sum_vld = 4'h0;
        do_start();
        repeat (6) @(posedge clk);
        #1 unit_res_ovrflw = 4'b0001;
        @(posedge clk);
        #1 unit_res_ovrflw = 4'b0000;
        @(negedge clk);
        chk("s6_res_set", 64'(res_ovrflw_any), 64'd1);
        chk("s6_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_busy", 64'(busy), 64'd0);
        chk("s6_async_res",  64'(res_ovrflw_any), 64'd0);
        chk("s6_async_vld",  64'(total_vld), 64'd0);
        chk("s6_async_sum",  total_sum, 64'd0);
        chk("s6_async_flags", {62'd0, total_ovrflw, timeout_err}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        unit_sum_vld = 4'hF;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("s6_idle_after_reset", 64'(busy), 64'd0);
        chk("s6_no_vld_after_reset", 64'(total_vld), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
